// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module : fifo_rd_pkg
// Brief  : Shared widths and types for the FIFO read-side word serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  localparam int IN_W  = 128;
  localparam int OUT_W = 32;
  localparam int BEATS = IN_W / OUT_W;

  typedef logic [IN_W-1:0]            word_t;
  typedef logic [OUT_W-1:0]           beat_t;
  typedef logic [$clog2(BEATS)-1:0]   beat_idx_t;
  typedef logic [1:0]                 occ_t;

endpackage

`default_nettype wire

// File: rtl/fifo_rd_wordbuf.sv
// ============================================================================
// Module : fifo_rd_wordbuf
// Brief  : Two-entry head/tail word buffer; push and pop may occur together.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_wordbuf
  import fifo_rd_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  i_push,
  input  word_t i_push_data,
  input  logic  i_pop,
  output word_t o_head,
  output occ_t  o_occ
);

  word_t r_head;
  word_t r_tail;
  occ_t  r_occ;

  // Pop is only ever requested with occ != 0 and push only with occ != 2
  // unless a pop happens in the same cycle.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= i_push_data;
          end else begin
            r_tail <= i_push_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= i_push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_head = r_head;
  assign o_occ  = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_serializer.sv
// ============================================================================
// Module : fifo_rd_serializer
// Brief  : Drains 128-bit FIFO words and re-emits them as narrow stream beats.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_serializer
  import fifo_rd_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  output logic        fifo_rden,
  input  word_t       fifo_rddata,
  input  logic        fifo_empty,
  input  logic        fifo_alm_empty,
  output logic        o_valid,
  output beat_t       o_data,
  output logic        o_last,
  input  logic        i_ready,
  output logic        o_busy
);

  if ((IN_W % OUT_W) != 0) begin : g_chk_ratio
    $error("fifo_rd_serializer: IN_W must be a multiple of OUT_W");
  end
  if (BEATS < 2) begin : g_chk_beats
    $error("fifo_rd_serializer: BEATS must be at least 2");
  end

  logic      r_inflight;
  beat_idx_t r_beat_idx;
  word_t     w_head;
  occ_t      w_occ;
  occ_t      w_pending;
  logic      w_xfer;
  logic      w_pop;

  fifo_rd_wordbuf u_wordbuf (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (r_inflight),
    .i_push_data (fifo_rddata),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

  // Held words plus the outstanding read never exceed two; the almost-empty
  // term stops a second read racing the last word out of the FIFO.
  assign w_pending = w_occ + {1'b0, r_inflight};
  assign fifo_rden = !rstn && !fifo_empty && (w_pending < 2'd2)
                     && (!r_inflight || !fifo_alm_empty);

  assign o_valid = (w_occ != 2'd0);
  assign o_data  = w_head[r_beat_idx*OUT_W +: OUT_W];
  assign o_last  = o_valid && (r_beat_idx == beat_idx_t'(BEATS-1));
  assign o_busy  = o_valid || r_inflight;

  assign w_xfer = o_valid && i_ready;
  assign w_pop  = w_xfer && o_last;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_inflight <= 1'b0;
      r_beat_idx <= '0;
    end else begin
      r_inflight <= fifo_rden;
      if (w_xfer) begin
        r_beat_idx <= o_last ? '0 : beat_idx_t'(r_beat_idx + 1'b1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_serializer.sv
// ============================================================================
// Module : tb_fifo_rd_serializer
// Brief  : Directed self-checking bench with a behavioural FIFO source.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_serializer;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         fifo_rden;
  logic [127:0] fifo_rddata = '0;
  logic         fifo_empty;
  logic         fifo_alm_empty;
  logic         o_valid;
  logic [31:0]  o_data;
  logic         o_last;
  logic         i_ready = 1'b0;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rd_serializer dut (
    .clk            (clk),
    .rstn           (rstn),
    .fifo_rden      (fifo_rden),
    .fifo_rddata    (fifo_rddata),
    .fifo_empty     (fifo_empty),
    .fifo_alm_empty (fifo_alm_empty),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_last         (o_last),
    .i_ready        (i_ready),
    .o_busy         (o_busy)
  );

  // Behavioural FIFO: read data appears the cycle after the strobe
  logic [127:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_alm_empty = ((wr_ptr - rd_ptr) <= 1);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_rddata <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // Stream monitor
  int          cyc = 0;
  int          rden_cnt = 0;
  int          uf_cnt = 0;
  int          nb = 0;
  logic [31:0] beat_data [0:255];
  logic        beat_last [0:255];
  int          beat_cyc  [0:255];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rden) begin
      rden_cnt <= rden_cnt + 1;
      if (fifo_empty) uf_cnt <= uf_cnt + 1;
    end
    if (o_valid && i_ready && nb < 256) begin
      beat_data[nb] <= o_data;
      beat_last[nb] <= o_last;
      beat_cyc[nb]  <= cyc;
      nb            <= nb + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [127:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [31:0] bt(input logic [7:0] tag, input int k, input int j);
    return {tag, 8'(k), 8'h00, 8'(j)};
  endfunction

  function automatic logic [127:0] mk(input logic [7:0] tag, input int k);
    return {bt(tag, k, 3), bt(tag, k, 2), bt(tag, k, 1), bt(tag, k, 0)};
  endfunction

  task automatic drain();
    for (int i = 0; i < 60 && o_busy; i++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    i_ready = 1'b0;
    push_word(128'h4444_4444_3333_3333_2222_2222_1111_1111);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden cyc%0d: got %b want 0", c, fifo_rden); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d: got %b want 0", c, o_valid); end
      checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data cyc%0d: got %h want 0", c, o_data); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d: got %b want 0", c, o_busy); end
    end
    rstn = 1'b0;
    #1;
    checks++; if (fifo_rden !== 1'b1) begin errors++; $display("FAIL first_rden: got %b want 1", fifo_rden); end
  endtask

  task automatic test_single_word();
    int s_r;
    logic [31:0] exp [0:3];
    exp[0] = 32'h1111_1111; exp[1] = 32'h2222_2222;
    exp[2] = 32'h3333_3333; exp[3] = 32'h4444_4444;
    s_r = rden_cnt;
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_lat_valid: got %b want 0", o_valid); end
    checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL single_no_rden: got %b want 0", fifo_rden); end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (o_valid !== 1'b1 || o_data !== exp[j]) begin errors++; $display("FAIL single_beat%0d: got v=%b %h want v=1 %h", j, o_valid, o_data, exp[j]); end
      checks++; if (o_last !== (j == 3)) begin errors++; $display("FAIL single_last%0d: got %b want %b", j, o_last, (j == 3)); end
    end
    tick();
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got v=%b busy=%b want 0 0", o_valid, o_busy); end
    checks++; if (rden_cnt - s_r !== 1) begin errors++; $display("FAIL single_rden_cnt: got %0d want 1", rden_cnt - s_r); end
  endtask

  task automatic test_streaming();
    int s_nb, s_r, s_u, bad_d, bad_l, gaps;
    s_nb = nb; s_r = rden_cnt; s_u = uf_cnt;
    bad_d = 0; bad_l = 0; gaps = 0;
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_word(mk(8'h50, k));
    for (int i = 0; i < 80 && (nb - s_nb) < 32; i++) tick();
    drain();
    checks++; if (nb - s_nb !== 32) begin errors++; $display("FAIL stream_count: got %0d want 32", nb - s_nb); end
    for (int i = 0; i < 32; i++) begin
      if (beat_data[s_nb+i] !== bt(8'h50, i/4, i%4)) bad_d++;
      if (beat_last[s_nb+i] !== ((i % 4) == 3)) bad_l++;
      if (i > 0 && beat_cyc[s_nb+i] != beat_cyc[s_nb+i-1] + 1) gaps++;
    end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL stream_data: got %0d bad beats want 0", bad_d); end
    checks++; if (bad_l != 0) begin errors++; $display("FAIL stream_last: got %0d bad flags want 0", bad_l); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d gaps want 0", gaps); end
    checks++; if (rden_cnt - s_r !== 8) begin errors++; $display("FAIL stream_rden_cnt: got %0d want 8", rden_cnt - s_r); end
    checks++; if (uf_cnt - s_u !== 0) begin errors++; $display("FAIL stream_underflow: got %0d want 0", uf_cnt - s_u); end
  endtask

  task automatic test_backpressure();
    int s_nb, s_r, bad_h, bad_d;
    s_nb = nb; s_r = rden_cnt; bad_h = 0; bad_d = 0;
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(mk(8'h60, k));
    for (int i = 0; i < 10 && !o_valid; i++) tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_valid !== 1'b1 || o_data !== 32'h6000_0001 || o_last !== 1'b0) bad_h++;
      tick();
    end
    checks++; if (bad_h != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_h); end
    checks++; if (rden_cnt - s_r > 2) begin errors++; $display("FAIL bp_rden_cnt: got %0d want <=2", rden_cnt - s_r); end
    i_ready = 1'b1;
    for (int i = 0; i < 80 && (nb - s_nb) < 20; i++) tick();
    drain();
    checks++; if (nb - s_nb !== 20) begin errors++; $display("FAIL bp_count: got %0d want 20", nb - s_nb); end
    for (int i = 0; i < 20; i++)
      if (beat_data[s_nb+i] !== bt(8'h60, i/4, i%4)) bad_d++;
    checks++; if (bad_d != 0) begin errors++; $display("FAIL bp_data: got %0d bad beats want 0", bad_d); end
    checks++; if (rden_cnt - s_r !== 5) begin errors++; $display("FAIL bp_rden_total: got %0d want 5", rden_cnt - s_r); end
  endtask

  task automatic test_underflow_guard();
    int s_nb, s_r, s_u, bad_d;
    s_nb = nb; s_r = rden_cnt; s_u = uf_cnt; bad_d = 0;
    i_ready = 1'b1;
    push_word(mk(8'h70, 0));
    push_word(mk(8'h70, 1));
    #1;
    checks++; if (fifo_rden !== 1'b1) begin errors++; $display("FAIL uf_rden0: got %b want 1", fifo_rden); end
    tick();
    checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL uf_blocked: got %b want 0", fifo_rden); end
    tick();
    checks++; if (fifo_rden !== 1'b1) begin errors++; $display("FAIL uf_rden1: got %b want 1", fifo_rden); end
    for (int i = 0; i < 40 && (nb - s_nb) < 8; i++) tick();
    drain();
    for (int i = 0; i < 8; i++)
      if (beat_data[s_nb+i] !== bt(8'h70, i/4, i%4)) bad_d++;
    checks++; if (nb - s_nb !== 8 || bad_d != 0) begin errors++; $display("FAIL uf_data: got %0d beats %0d bad want 8 0", nb - s_nb, bad_d); end
    checks++; if (uf_cnt - s_u !== 0) begin errors++; $display("FAIL uf_underflow: got %0d want 0", uf_cnt - s_u); end
    checks++; if (rden_cnt - s_r !== 2) begin errors++; $display("FAIL uf_rden_cnt: got %0d want 2", rden_cnt - s_r); end
  endtask

  task automatic test_reset_mid_word();
    int s_nb, bad_d;
    bad_d = 0;
    i_ready = 1'b1;
    push_word(mk(8'h80, 0));
    tick();
    tick();
    checks++; if (o_data !== 32'h8000_0000) begin errors++; $display("FAIL rm_beat0: got %h want 80000000", o_data); end
    tick();
    push_word(mk(8'h80, 1));
    push_word(mk(8'h80, 2));
    tick();
    checks++; if (o_data !== 32'h8000_0002 || o_busy !== 1'b1) begin errors++; $display("FAIL rm_beat2: got %h busy=%b want 80000002 1", o_data, o_busy); end
    rstn = 1'b1;
    tick();
    checks++; if ({fifo_rden, o_valid, o_last, o_busy} !== 4'b0000 || o_data !== 32'h0) begin errors++; $display("FAIL rm_cleared: got rden=%b v=%b last=%b busy=%b data=%h want all 0", fifo_rden, o_valid, o_last, o_busy, o_data); end
    rstn = 1'b0;
    #1;
    checks++; if (fifo_rden !== 1'b1) begin errors++; $display("FAIL rm_restart_rden: got %b want 1", fifo_rden); end
    s_nb = nb;
    for (int i = 0; i < 20 && (nb - s_nb) < 4; i++) tick();
    drain();
    for (int i = 0; i < 4; i++)
      if (beat_data[s_nb+i] !== bt(8'h80, 2, i)) bad_d++;
    checks++; if (nb - s_nb !== 4 || bad_d != 0) begin errors++; $display("FAIL rm_restart_data: got %0d beats %0d bad want 4 0", nb - s_nb, bad_d); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_underflow_guard();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
